cdr_period_ctrl: RTL and testbench

CDR_PERIOD_CTRL -- requirements
Module: cdr_period_ctrl

---
 rtl/cdr_period_ctrl.sv | 126 ++++++++++++
 tb/tb_cdr_period_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_period_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// cdr_period_ctrl: vote-driven sample-period controller for a CDR loop
// Rev 1.0
// ------------------------------------------------------------------
module cdr_period_ctrl #(
  parameter int W       = 6,
  parameter int P_NOM   = 25,
  parameter int P_MIN   = 23,
  parameter int P_MAX   = 27,
  parameter int STEP    = 2,
  parameter int VOTE_TH = 4,
  parameter int LOCK_N  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_T,
  input  logic         i_E,
  output logic [W-1:0] o_nb_P,
  output logic         o_sample,
  output logic         o_lock,
  output logic         o_sat
);

  localparam int AW = $clog2(VOTE_TH + 1) + 1;
  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic signed [AW-1:0] c_TH_POS = AW'(VOTE_TH);
  localparam logic signed [AW-1:0] c_TH_NEG = -c_TH_POS;
  localparam logic signed [AW-1:0] c_ONE    = AW'(1);
  localparam logic [W:0]           c_STEP   = (W+1)'(STEP);
  localparam logic [W:0]           c_PMIN   = (W+1)'(P_MIN);
  localparam logic [W:0]           c_PMAX   = (W+1)'(P_MAX);
  localparam logic [W:0]           c_ONE_P  = (W+1)'(1);
  localparam logic [W-1:0]         c_PNOM   = W'(P_NOM);
  localparam logic [LW-1:0]        c_LOCK   = LW'(LOCK_N);

  logic [W-1:0]         cnt_q, cnt_d;
  logic [W-1:0]         nb_p_q, nb_p_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                 lock_q, lock_d;

  logic [W:0]           w_p_x, w_p_up, w_p_dn, w_last;
  logic                 w_can_up, w_can_dn, w_wrap;
  logic signed [AW-1:0] w_acc_nx;
  logic                 w_hit_up, w_hit_dn, w_adj_up, w_adj_dn, w_adj, w_blk;

  // Bound checks run one bit wider than the period so neither direction can wrap.
  assign w_p_x    = {1'b0, nb_p_q};
  assign w_p_up   = w_p_x + c_STEP;
  assign w_p_dn   = w_p_x - c_STEP;
  assign w_last   = w_p_x - c_ONE_P;
  assign w_can_up = (w_p_up <= c_PMAX);
  assign w_can_dn = (w_p_x >= c_STEP) && (w_p_dn >= c_PMIN);
  assign w_wrap   = ({1'b0, cnt_q} == w_last);

  assign o_sample = i_en & w_wrap;
  assign o_nb_P   = nb_p_q;
  assign o_lock   = lock_q;
  assign o_sat    = ~w_can_up | ~w_can_dn;

  always_comb begin
    w_acc_nx = acc_q;
    if (i_en && i_T) begin
      if (i_E) begin
        if (acc_q < c_TH_POS) w_acc_nx = acc_q + c_ONE;
      end else begin
        if (acc_q > c_TH_NEG) w_acc_nx = acc_q - c_ONE;
      end
    end
  end

  assign w_hit_up = (w_acc_nx >= c_TH_POS);
  assign w_hit_dn = (w_acc_nx <= c_TH_NEG);
  assign w_adj_up = o_sample & w_hit_up & w_can_up;
  assign w_adj_dn = o_sample & w_hit_dn & w_can_dn;
  assign w_adj    = w_adj_up | w_adj_dn;
  assign w_blk    = o_sample & ((w_hit_up & ~w_can_up) | (w_hit_dn & ~w_can_dn));

  always_comb begin
    cnt_d      = cnt_q;
    nb_p_d     = nb_p_q;
    acc_d      = acc_q;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (i_clr) begin
      cnt_d      = '0;
      nb_p_d     = c_PNOM;
      acc_d      = '0;
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end else if (i_en) begin
      // The new period takes effect on the same edge the counter wraps.
      cnt_d = w_wrap ? '0 : cnt_q + W'(1);
      acc_d = (w_adj || w_blk) ? '0 : w_acc_nx;
      if (w_adj_up)      nb_p_d = w_p_up[W-1:0];
      else if (w_adj_dn) nb_p_d = w_p_dn[W-1:0];
      if (o_sample) begin
        if (w_adj)                    lock_cnt_d = '0;
        else if (lock_cnt_q != c_LOCK) lock_cnt_d = lock_cnt_q + LW'(1);
      end
      lock_d = (lock_cnt_d == c_LOCK);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      nb_p_q     <= c_PNOM;
      acc_q      <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      nb_p_q     <= nb_p_d;
      acc_q      <= acc_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdr_period_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cdr_period_ctrl: directed scenarios plus random votes vs. a model
// Rev 1.0
// ------------------------------------------------------------------
module tb_cdr_period_ctrl;

  localparam int W = 6, P_NOM = 25, P_MIN = 23, P_MAX = 27, STEP = 2, VT = 4, LN = 8;

  logic         clk = 1'b0;
  logic         rst, en, clr, t_v, e_v;
  logic [W-1:0] nb_p;
  logic         smp, lck, sat;

  cdr_period_ctrl #(.W(W), .P_NOM(P_NOM), .P_MIN(P_MIN), .P_MAX(P_MAX), .STEP(STEP),
                    .VOTE_TH(VT), .LOCK_N(LN)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_T(t_v), .i_E(e_v),
    .o_nb_P(nb_p), .o_sample(smp), .o_lock(lck), .o_sat(sat));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: period, position within period, net votes, strobes since last change.
  int m_p, m_cnt, m_acc, m_lc;
  bit m_lock;

  function automatic void model_reset();
    m_p = P_NOM; m_cnt = 0; m_acc = 0; m_lc = 0; m_lock = 0;
  endfunction

  function automatic void model_step();
    int a;
    bit adj, blk;
    if (clr) begin model_reset(); return; end
    if (!en) return;
    a = m_acc;
    if (t_v) a = e_v ? ((a + 1 > VT) ? VT : a + 1) : ((a - 1 < -VT) ? -VT : a - 1);
    if (m_cnt == m_p - 1) begin
      adj = 0; blk = 0;
      if (a >= VT) begin
        if (m_p + STEP <= P_MAX) begin m_p += STEP; adj = 1; end else blk = 1;
      end else if (a <= -VT) begin
        if (m_p - STEP >= P_MIN) begin m_p -= STEP; adj = 1; end else blk = 1;
      end
      if (adj || blk) a = 0;
      m_lc   = adj ? 0 : ((m_lc < LN) ? m_lc + 1 : LN);
      m_lock = (m_lc == LN);
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    m_acc = a;
  endfunction

  function automatic bit m_sample();
    return en && (m_cnt == m_p - 1);
  endfunction

  function automatic bit m_sat();
    return (m_p + STEP > P_MAX) || (m_p - STEP < P_MIN);
  endfunction

  task automatic apply(input bit e_n, input bit c, input bit t, input bit d);
    en = e_n; clr = c; t_v = t; e_v = d;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One period with nv votes at its start and optionally one more in the strobe cycle.
  task automatic run_period(input int len, input int nv, input bit dir, input bit at_strobe,
                            output int strobe_at);
    strobe_at = -1;
    for (int k = 0; k < len + 3 && strobe_at < 0; k++) begin
      apply(1'b1, 1'b0, (k < nv) || (at_strobe && k == len - 1), dir);
      if (smp === 1'b1) strobe_at = k;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; t_v = 1'b0; e_v = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (int'(nb_p) !== P_NOM) begin n_fail++; $display("FAIL reset.nb_P got=%0d exp=%0d", nb_p, P_NOM); end
    n_chk++; if (smp !== 1'b0) begin n_fail++; $display("FAIL reset.sample got=%b exp=0", smp); end
    n_chk++; if (lck !== 1'b0) begin n_fail++; $display("FAIL reset.lock got=%b exp=0", lck); end
    n_chk++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset.sat got=%b exp=0", sat); end
    rst = 1'b0;
  endtask

  task automatic test_no_votes();
    for (int k = 0; k < 8 * P_NOM; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      n_chk++; if (smp !== (k % P_NOM == P_NOM - 1)) begin n_fail++; $display("FAIL novote.sample k=%0d got=%b exp=%b", k, smp, (k % P_NOM == P_NOM - 1)); end
      n_chk++; if (lck !== 1'b0) begin n_fail++; $display("FAIL novote.lock_early k=%0d got=%b exp=0", k, lck); end
      n_chk++; if (int'(nb_p) !== P_NOM || sat !== 1'b0) begin n_fail++; $display("FAIL novote.period k=%0d got=%0d/%b exp=%0d/0", k, nb_p, sat, P_NOM); end
      step();
    end
    n_chk++; if (lck !== 1'b1) begin n_fail++; $display("FAIL novote.lock_after8 got=%b exp=1", lck); end
  endtask

  task automatic test_early_adjust();
    int s;
    run_period(25, 4, 1'b1, 1'b0, s);
    n_chk++; if (s !== 24) begin n_fail++; $display("FAIL early.strobe got=%0d exp=24", s); end
    n_chk++; if (int'(nb_p) !== 27) begin n_fail++; $display("FAIL early.nb_P got=%0d exp=27", nb_p); end
    n_chk++; if (lck !== 1'b0) begin n_fail++; $display("FAIL early.lock got=%b exp=0", lck); end
    n_chk++; if (sat !== 1'b1) begin n_fail++; $display("FAIL early.sat got=%b exp=1", sat); end
    run_period(27, 0, 1'b0, 1'b0, s);
    n_chk++; if (s !== 26) begin n_fail++; $display("FAIL early.interval got=%0d exp=26", s); end
  endtask

  task automatic test_blocked();
    int s;
    run_period(27, 4, 1'b1, 1'b0, s);
    n_chk++; if (s !== 26) begin n_fail++; $display("FAIL blocked.strobe got=%0d exp=26", s); end
    n_chk++; if (int'(nb_p) !== 27) begin n_fail++; $display("FAIL blocked.nb_P got=%0d exp=27", nb_p); end
    n_chk++; if (dut.acc_q !== '0) begin n_fail++; $display("FAIL blocked.acc got=%0d exp=0", dut.acc_q); end
    n_chk++; if (int'(dut.lock_cnt_q) !== 2) begin n_fail++; $display("FAIL blocked.lock_cnt got=%0d exp=2", dut.lock_cnt_q); end
    n_chk++; if (sat !== 1'b1) begin n_fail++; $display("FAIL blocked.sat got=%b exp=1", sat); end
  endtask

  task automatic test_strobe_vote();
    int s;
    bit seen;
    run_period(27, 3, 1'b0, 1'b1, s);
    n_chk++; if (s !== 26 || int'(nb_p) !== 25) begin n_fail++; $display("FAIL strobevote.late got=%0d@%0d exp=25@26", nb_p, s); end
    run_period(25, 3, 1'b1, 1'b1, s);
    n_chk++; if (s !== 24 || int'(nb_p) !== 27) begin n_fail++; $display("FAIL strobevote.early got=%0d@%0d exp=27@24", nb_p, s); end
    seen = 1'b0;
    for (int k = 0; k < 27; k++) begin
      apply(1'b1, 1'b0, k < 6, k < 3);
      if (k == 26) seen = smp;
      step();
    end
    n_chk++; if (seen !== 1'b1 || int'(nb_p) !== 27) begin n_fail++; $display("FAIL strobevote.cancel got=%0d strobe=%b exp=27 strobe=1", nb_p, seen); end
    n_chk++; if (dut.acc_q !== '0) begin n_fail++; $display("FAIL strobevote.acc got=%0d exp=0", dut.acc_q); end
  endtask

  task automatic test_late_spread();
    int s;
    run_period(27, 4, 1'b0, 1'b0, s);
    n_chk++; if (int'(nb_p) !== 25 || sat !== 1'b0) begin n_fail++; $display("FAIL late.first got=%0d/%b exp=25/0", nb_p, sat); end
    run_period(25, 4, 1'b0, 1'b0, s);
    n_chk++; if (int'(nb_p) !== 23 || sat !== 1'b1) begin n_fail++; $display("FAIL late.second got=%0d/%b exp=23/1", nb_p, sat); end
    run_period(23, 4, 1'b0, 1'b0, s);
    n_chk++; if (s !== 22 || int'(nb_p) !== 23) begin n_fail++; $display("FAIL late.blocked got=%0d@%0d exp=23@22", nb_p, s); end
  endtask

  task automatic test_async_reset();
    int s;
    run_period(23, 4, 1'b1, 1'b0, s);
    run_period(25, 4, 1'b1, 1'b0, s);
    n_chk++; if (int'(nb_p) !== 27) begin n_fail++; $display("FAIL arst.setup got=%0d exp=27", nb_p); end
    for (int k = 0; k < 10; k++) begin apply(1'b1, 1'b0, 1'b0, 1'b0); step(); end
    n_chk++; if (int'(dut.cnt_q) !== 10) begin n_fail++; $display("FAIL arst.cnt_before got=%0d exp=10", dut.cnt_q); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_chk++; if (int'(nb_p) !== 25 || int'(dut.cnt_q) !== 0) begin n_fail++; $display("FAIL arst.immediate got=%0d/%0d exp=25/0", nb_p, dut.cnt_q); end
    n_chk++; if (smp !== 1'b0 || lck !== 1'b0) begin n_fail++; $display("FAIL arst.outputs got=%b/%b exp=0/0", smp, lck); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_clr_freeze();
    bit seen;
    for (int k = 0; k < 10; k++) begin apply(1'b1, 1'b0, 1'b0, 1'b0); step(); end
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1);
      n_chk++; if (smp !== 1'b0 || int'(dut.cnt_q) !== 10 || int'(nb_p) !== 25) begin n_fail++; $display("FAIL freeze k=%0d got=%b/%0d/%0d exp=0/10/25", k, smp, dut.cnt_q, nb_p); end
      step();
    end
    n_chk++; if (dut.acc_q !== '0) begin n_fail++; $display("FAIL freeze.acc got=%0d exp=0", dut.acc_q); end
    apply(1'b0, 1'b1, 1'b0, 1'b0); step();
    n_chk++; if (int'(dut.cnt_q) !== 0) begin n_fail++; $display("FAIL clr.no_en got=%0d exp=0", dut.cnt_q); end
    for (int k = 0; k < 24; k++) begin apply(1'b1, 1'b0, k < 3, 1'b1); step(); end
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    seen = smp;
    step();
    n_chk++; if (seen !== 1'b1 || int'(nb_p) !== 25) begin n_fail++; $display("FAIL clr.priority got=%0d strobe=%b exp=25 strobe=1", nb_p, seen); end
    n_chk++; if (int'(dut.cnt_q) !== 0 || dut.acc_q !== '0) begin n_fail++; $display("FAIL clr.state got=%0d/%0d exp=0/0", dut.cnt_q, dut.acc_q); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      apply($urandom_range(9, 0) != 0, $urandom_range(399, 0) == 0,
            $urandom_range(9, 0) < 4, $urandom_range(1, 0) == 1);
      n_chk++; if (smp !== m_sample()) begin n_fail++; $display("FAIL rand.sample k=%0d got=%b exp=%b", k, smp, m_sample()); end
      n_chk++; if (int'(nb_p) !== m_p) begin n_fail++; $display("FAIL rand.nb_P k=%0d got=%0d exp=%0d", k, nb_p, m_p); end
      n_chk++; if (sat !== m_sat()) begin n_fail++; $display("FAIL rand.sat k=%0d got=%b exp=%b", k, sat, m_sat()); end
      n_chk++; if (lck !== m_lock) begin n_fail++; $display("FAIL rand.lock k=%0d got=%b exp=%b", k, lck, m_lock); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_no_votes();
    test_early_adjust();
    test_blocked();
    test_strobe_vote();
    test_late_spread();
    test_async_reset();
    test_clr_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
